branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Control-flow stage directly upstream of the program counter. Consumes the decoded
//  opcode/argument of the instruction at the current PC and drives the PC's pc_set and
//  pc_set_addr load inputs for JMP, JZ, CALL and RET.
//  Holds a return-address stack and squashes wrong-path instructions after a taken branch.
// PARAMETERS
//  ADDR_W       8     PC/argument width; equals `ARG_WIDTH
//  OPC_W        4     opcode width
//  STACK_DEPTH  4     return-address stack entries (>=1)
//  FLUSH_CYC    2     cycles of squash after pc_set; covers fetch latency (>=1)
//  OP_JMP       4'hA  unconditional jump to arg
//  OP_JZ        4'hB  jump to arg if zero_flag==1
//  OP_CALL      4'hC  push pc_cur+1, jump to arg
//  OP_RET       4'hD  pop address, jump to it
// PORTS
//  CLK          in   1        clock, all state on posedge
//  RST          in   1        synchronous reset, active-high
//  instr_valid  in   1        opcode/arg/pc_cur/zero_flag valid this cycle
//  opcode       in   OPC_W    decoded opcode of current instruction
//  arg          in   ADDR_W   instruction argument (branch target)
//  pc_cur       in   ADDR_W   address of current instruction (PC counter value)
//  zero_flag    in   1        ALU zero flag, sampled with JZ
//  pc_set       out  1        registered; PC load enable
//  pc_set_addr  out  ADDR_W   registered; PC load value
//  flush        out  1        registered; squash fetched instruction this cycle
//  stack_ovf    out  1        sticky: CALL with stack full
//  stack_unf    out  1        sticky: RET with stack empty
// BEHAVIOUR
//  Reset: state=RUN, pc_set=0, pc_set_addr=0, flush=0, stack count=0, stack_ovf=0, stack_unf=0.
//   Entries not cleared but unreachable. RST wins over all other events, mid-SET/FLUSH too.
//  FSM states:
//   RUN: accept instruction when instr_valid && !flush.
//   SET: pc_set=1 exactly one cycle.
//   FLUSH: flush=1 for FLUSH_CYC cycles, then RUN.
//  RUN, taken branch at edge N: state->SET; pc_set=1 and pc_set_addr=target during cycle N+1.
//   PC loads target at end of N+1.
//  Taken: JMP always; JZ iff zero_flag=1; CALL always; RET iff stack non-empty.
//  Not-taken JZ, other opcodes, instr_valid=0: stay RUN, no outputs change, stack untouched.
//  flush: asserted during SET and FLUSH_CYC cycles of FLUSH, so SET+FLUSH_CYC cycles total.
//   Instructions presented while flush=1 are ignored entirely (no stack, no flags).
//  CALL: push (pc_cur+1) mod 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8); target=arg.
//   Stack full: no push, stack_ovf<=1, jump still taken; oldest entries preserved.
//  RET: target=top entry, pop.
//   Stack empty: stack_unf<=1, treated as NOP (no pc_set, no flush).
//  Stack is LIFO, count 0..STACK_DEPTH. Push/pop only at the accepting edge in RUN;
//   never both in one cycle.
//  pc_set_addr holds its last value after pc_set drops. Sticky flags clear only on RST.
//  Latency: accepted instruction -> pc_set high exactly 1 cycle later. Throughput: one
//   branch per 1+FLUSH_CYC+1 cycles minimum.
// TESTING
//  1. RST, then JMP arg=0x20 valid at edge N -> pc_set=1,addr=0x20 in N+1 only; flush=1 N+1..N+3; RUN at N+4.
//  2. JZ arg=0x30, zero_flag=0 -> no pc_set/flush; same with zero_flag=1 -> pc_set addr=0x30.
//  3. CALL pc_cur=0x10 arg=0x40, wait flush, RET -> pc_set addr=0x11; stack count back to 0.
//  4. 5 nested CALLs (DEPTH=4) -> 5th jumps, stack_ovf=1; 4 RETs return in LIFO order; 5th RET -> stack_unf=1, no pc_set.
//  5. CALL at pc_cur=0xFF -> pushed 0x00; JMP presented while flush=1 -> ignored.
//  6. RST asserted in SET and in FLUSH -> next cycle pc_set=0, flush=0, flags 0, stack empty.

Source files
------------

// File: rtl/branch_ctrl.sv
// Control-flow stage ahead of the program counter: resolves JMP/JZ/CALL/RET,
// keeps a return-address stack and squashes wrong-path fetches after a redirect.
module branch_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned FLUSH_CYC   = 2,
  parameter logic [OPC_W-1:0] OP_JMP  = 4'hA,
  parameter logic [OPC_W-1:0] OP_JZ   = 4'hB,
  parameter logic [OPC_W-1:0] OP_CALL = 4'hC,
  parameter logic [OPC_W-1:0] OP_RET  = 4'hD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] arg,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              zero_flag,
  output logic              pc_set,
  output logic [ADDR_W-1:0] pc_set_addr,
  output logic              flush,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("branch_ctrl: STACK_DEPTH must be at least 1");
  end
  if (FLUSH_CYC < 1) begin : g_bad_flush
    $error("branch_ctrl: FLUSH_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET,
    ST_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flushCnt_q, flushCnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              pcSet_q, pcSet_d;
  logic [ADDR_W-1:0] pcSetAddr_q, pcSetAddr_d;
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              accept;
  logic              stackFull;
  logic              stackEmpty;
  logic [PTR_W-1:0]  topIdx;
  logic [PTR_W-1:0]  pushIdx;
  logic [ADDR_W-1:0] pushData;
  logic              push;
  logic              pop;
  logic              taken;
  logic [ADDR_W-1:0] target;

  assign accept     = instr_valid && !flush_q;
  assign stackFull  = (count_q == CNT_W'(STACK_DEPTH));
  assign stackEmpty = (count_q == '0);
  assign topIdx     = PTR_W'(count_q - CNT_W'(1));
  assign pushIdx    = PTR_W'(count_q);
  assign pushData   = pc_cur + ADDR_W'(1);

  // Next-state logic; outputs are registered from the state being entered.
  always_comb begin
    state_d     = state_q;
    flushCnt_d  = flushCnt_q;
    count_d     = count_q;
    pcSetAddr_d = pcSetAddr_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push        = 1'b0;
    pop         = 1'b0;
    taken       = 1'b0;
    target      = arg;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (opcode)
            OP_JMP: taken = 1'b1;
            OP_JZ:  taken = zero_flag;
            OP_CALL: begin
              taken = 1'b1;
              if (stackFull) begin
                ovf_d = 1'b1;
              end else begin
                push    = 1'b1;
                count_d = count_q + CNT_W'(1);
              end
            end
            OP_RET: begin
              if (stackEmpty) begin
                unf_d = 1'b1;
              end else begin
                taken   = 1'b1;
                pop     = 1'b1;
                target  = stack_q[topIdx];
                count_d = count_q - CNT_W'(1);
              end
            end
            default: ;
          endcase
          if (taken) begin
            state_d     = ST_SET;
            pcSetAddr_d = target;
          end
        end
      end
      ST_SET: begin
        state_d    = ST_FLUSH;
        flushCnt_d = FC_W'(FLUSH_CYC - 1);
      end
      ST_FLUSH: begin
        if (flushCnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flushCnt_d = flushCnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    pcSet_d = (state_d == ST_SET);
    flush_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      flushCnt_q  <= '0;
      count_q     <= '0;
      pcSet_q     <= 1'b0;
      pcSetAddr_q <= '0;
      flush_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flushCnt_q  <= flushCnt_d;
      count_q     <= count_d;
      pcSet_q     <= pcSet_d;
      pcSetAddr_q <= pcSetAddr_d;
      flush_q     <= flush_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Entries are never cleared; the count alone decides what is reachable.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      stack_q[pushIdx] <= pushData;
    end
  end

  assign pc_set      = pcSet_q;
  assign pc_set_addr = pcSetAddr_q;
  assign flush       = flush_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && pop));
      assert (!pcSet_q || flush_q);
      assert (count_q <= CNT_W'(STACK_DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, hand-written
// corner sequences, then random stimulus against a queue-based reference model.
module tb_branch_ctrl;

  localparam int FLUSH_CYC = 2;
  localparam int DEPTH     = 4;
  localparam logic [3:0] JMP  = 4'hA;
  localparam logic [3:0] JZ   = 4'hB;
  localparam logic [3:0] CALL = 4'hC;
  localparam logic [3:0] RET  = 4'hD;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       instrValid = 1'b0;
  logic [3:0] opcode = '0;
  logic [7:0] arg = '0;
  logic [7:0] pcCur = '0;
  logic       zeroFlag = 1'b0;
  logic       pcSet;
  logic [7:0] pcSetAddr;
  logic       flush;
  logic       stackOvf;
  logic       stackUnf;

  int total = 0;
  int bad = 0;

  // Reference model: cycles of squash remaining plus a plain LIFO queue.
  int         mBusy = 0;
  logic [7:0] mStack[$];
  logic       mPcSet = 1'b0;
  logic [7:0] mAddr = '0;
  logic       mFlush = 1'b0;
  logic       mOvf = 1'b0;
  logic       mUnf = 1'b0;

  branch_ctrl #(
    .ADDR_W(8), .OPC_W(4), .STACK_DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .instr_valid(instrValid),
    .opcode(opcode),
    .arg(arg),
    .pc_cur(pcCur),
    .zero_flag(zeroFlag),
    .pc_set(pcSet),
    .pc_set_addr(pcSetAddr),
    .flush(flush),
    .stack_ovf(stackOvf),
    .stack_unf(stackUnf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] opc;
    logic [7:0] arg;
    logic [7:0] pc;
    logic       zf;
    logic       expPcSet;
    logic [7:0] expAddr;
    logic       expFlush;
    logic       expOvf;
    logic       expUnf;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mkVec(input logic r, input logic v, input logic [3:0] o,
                                 input logic [7:0] a, input logic [7:0] p, input logic z,
                                 input logic eSet, input logic [7:0] eAddr,
                                 input logic eFl, input logic eOvf, input logic eUnf);
    vec_t t;
    t.rst = r; t.valid = v; t.opc = o; t.arg = a; t.pc = p; t.zf = z;
    t.expPcSet = eSet; t.expAddr = eAddr; t.expFlush = eFl;
    t.expOvf = eOvf; t.expUnf = eUnf;
    return t;
  endfunction

  task automatic modelEdge();
    logic       tk;
    logic [7:0] tgt;
    tk  = 1'b0;
    tgt = arg;
    if (RST) begin
      mBusy = 0;
      mStack.delete();
      mAddr = '0;
      mOvf  = 1'b0;
      mUnf  = 1'b0;
    end else if (mBusy > 0) begin
      mBusy--;
    end else if (instrValid) begin
      if (opcode == JMP) tk = 1'b1;
      else if (opcode == JZ) tk = zeroFlag;
      else if (opcode == CALL) begin
        tk = 1'b1;
        if (mStack.size() < DEPTH) mStack.push_back(pcCur + 8'd1);
        else mOvf = 1'b1;
      end else if (opcode == RET) begin
        if (mStack.size() > 0) begin
          tk  = 1'b1;
          tgt = mStack.pop_back();
        end else begin
          mUnf = 1'b1;
        end
      end
      if (tk) begin
        mBusy = 1 + FLUSH_CYC;
        mAddr = tgt;
      end
    end
    mPcSet = (mBusy == 1 + FLUSH_CYC);
    mFlush = (mBusy > 0);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] o,
                               input logic [7:0] a, input logic [7:0] p, input logic z);
    RST = r; instrValid = v; opcode = o; arg = a; pcCur = p; zeroFlag = z;
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic checkConst(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkConst({tag, ".pc_set"},      32'(pcSet),     32'(mPcSet));
    checkConst({tag, ".pc_set_addr"}, 32'(pcSetAddr), 32'(mAddr));
    checkConst({tag, ".flush"},       32'(flush),     32'(mFlush));
    checkConst({tag, ".stack_ovf"},   32'(stackOvf),  32'(mOvf));
    checkConst({tag, ".stack_unf"},   32'(stackUnf),  32'(mUnf));
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 4'h0, 8'h00, 8'h00, 0);
      checkOutput(tag);
    end
  endtask

  initial begin
    tbl[0]  = mkVec(1, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 0, 0);
    tbl[1]  = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 0, 0);
    tbl[2]  = mkVec(0, 1, JMP,  8'h20, 8'h05, 0,  1, 8'h20, 1, 0, 0);
    tbl[3]  = mkVec(0, 1, JMP,  8'h50, 8'h06, 0,  0, 8'h20, 1, 0, 0);
    tbl[4]  = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h20, 1, 0, 0);
    tbl[5]  = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h20, 0, 0, 0);
    tbl[6]  = mkVec(0, 1, JZ,   8'h30, 8'h20, 0,  0, 8'h20, 0, 0, 0);
    tbl[7]  = mkVec(0, 1, JZ,   8'h30, 8'h21, 1,  1, 8'h30, 1, 0, 0);
    tbl[8]  = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h30, 1, 0, 0);
    tbl[9]  = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h30, 1, 0, 0);
    tbl[10] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h30, 0, 0, 0);
    tbl[11] = mkVec(0, 1, CALL, 8'h40, 8'h10, 0,  1, 8'h40, 1, 0, 0);
    tbl[12] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h40, 1, 0, 0);
    tbl[13] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h40, 1, 0, 0);
    tbl[14] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h40, 0, 0, 0);
    tbl[15] = mkVec(0, 1, RET,  8'h77, 8'h40, 0,  1, 8'h11, 1, 0, 0);
    tbl[16] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h11, 1, 0, 0);
    tbl[17] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h11, 1, 0, 0);
    tbl[18] = mkVec(0, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h11, 0, 0, 0);
    tbl[19] = mkVec(0, 1, RET,  8'h00, 8'h11, 0,  0, 8'h11, 0, 0, 1);
    tbl[20] = mkVec(0, 1, 4'h3, 8'h55, 8'h12, 1,  0, 8'h11, 0, 0, 1);
    tbl[21] = mkVec(1, 0, 4'h0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].opc, tbl[i].arg, tbl[i].pc, tbl[i].zf);
      checkConst($sformatf("vec%0d.pc_set", i),      32'(pcSet),     32'(tbl[i].expPcSet));
      checkConst($sformatf("vec%0d.pc_set_addr", i), 32'(pcSetAddr), 32'(tbl[i].expAddr));
      checkConst($sformatf("vec%0d.flush", i),       32'(flush),     32'(tbl[i].expFlush));
      checkConst($sformatf("vec%0d.stack_ovf", i),   32'(stackOvf),  32'(tbl[i].expOvf));
      checkConst($sformatf("vec%0d.stack_unf", i),   32'(stackUnf),  32'(tbl[i].expUnf));
    end

    // Nested calls past the stack depth, then unwind one further than pushed.
    applyStimulus(1, 0, 4'h0, 8'h00, 8'h00, 0);
    checkOutput("nest_rst");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, CALL, 8'h40 + 8'(i), 8'h01 + 8'(i), 0);
      checkOutput("nest_call");
      checkConst("nest_call_target", 32'(pcSetAddr), 32'(8'h40 + 8'(i)));
      idle(1 + FLUSH_CYC, "nest_call_idle");
    end
    checkConst("ovf_after_5_calls", 32'(stackOvf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, RET, 8'h00, 8'h80, 0);
      checkOutput("nest_ret");
      checkConst("ret_lifo_addr", 32'(pcSetAddr), 32'(8'h05 - 8'(i)));
      checkConst("ret_lifo_pcset", 32'(pcSet), 32'd1);
      idle(1 + FLUSH_CYC, "nest_ret_idle");
    end
    applyStimulus(0, 1, RET, 8'h00, 8'h80, 0);
    checkOutput("ret_empty");
    checkConst("unf_5th_ret", 32'(stackUnf), 32'd1);
    checkConst("no_pcset_5th_ret", 32'(pcSet), 32'd0);
    checkConst("no_flush_5th_ret", 32'(flush), 32'd0);

    // Return address wraps at the top of the address space; flushed JMP ignored.
    applyStimulus(1, 0, 4'h0, 8'h00, 8'h00, 0);
    applyStimulus(0, 1, CALL, 8'h60, 8'hFF, 0);
    checkOutput("wrap_call");
    applyStimulus(0, 1, JMP, 8'h99, 8'h60, 0);
    checkOutput("flushed_jmp");
    checkConst("flushed_jmp_addr", 32'(pcSetAddr), 32'h60);
    checkConst("flushed_jmp_pcset", 32'(pcSet), 32'd0);
    idle(FLUSH_CYC, "wrap_idle");
    applyStimulus(0, 1, RET, 8'h00, 8'h61, 0);
    checkOutput("wrap_ret");
    checkConst("wrap_ret_addr", 32'(pcSetAddr), 32'h00);
    idle(1 + FLUSH_CYC, "wrap_ret_idle");

    // Reset landing in SET, then in FLUSH, must clear everything including the stack.
    applyStimulus(0, 1, CALL, 8'h70, 8'h20, 0);
    checkOutput("rst_set_call");
    applyStimulus(1, 0, 4'h0, 8'h00, 8'h00, 0);
    checkOutput("rst_in_set");
    checkConst("rst_in_set_pcset", 32'(pcSet), 32'd0);
    checkConst("rst_in_set_flush", 32'(flush), 32'd0);
    applyStimulus(0, 1, RET, 8'h00, 8'h30, 0);
    checkOutput("rst_stack_empty");
    checkConst("rst_stack_empty_unf", 32'(stackUnf), 32'd1);
    applyStimulus(0, 1, JMP, 8'h33, 8'h31, 0);
    checkOutput("rst_flush_jmp");
    idle(1, "rst_flush_wait");
    applyStimulus(1, 0, 4'h0, 8'h00, 8'h00, 0);
    checkOutput("rst_in_flush");
    checkConst("rst_in_flush_flush", 32'(flush), 32'd0);
    checkConst("rst_in_flush_unf", 32'(stackUnf), 32'd0);
    applyStimulus(0, 1, JMP, 8'h44, 8'h00, 0);
    checkOutput("post_rst_jmp");
    checkConst("post_rst_jmp_pcset", 32'(pcSet), 32'd1);

    // Random traffic biased towards control-flow opcodes.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] o;
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       o = JMP;
        1:       o = JZ;
        2, 3:    o = CALL;
        4, 5:    o = RET;
        default: o = 4'($urandom_range(0, 15));
      endcase
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), o,
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
